data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory side of the MemRead/MemWrite/BE request interface driven by the multicycle CPU control FSM.
- Accepts one load or store request at a time and inserts a configurable number of wait states.
- Performs byte-lane alignment, store byte-merge and load sign/zero extension per funct3.
- Returns a one-cycle MemReady completion pulse so the control FSM can hold in its MEM state until the access completes.

Parameters:
ADDR_WIDTH, 10, log2 of word count; storage is 2^ADDR_WIDTH x 32-bit words.
LATENCY, 2, wait-state cycles between request acceptance and access cycle (0..15).

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous, active-high reset
MemRead  input  1  load request, sampled only in IDLE
MemWrite  input  1  store request, sampled only in IDLE
ADDR  input  ADDR_WIDTH+2  byte address
BE  input  4  unshifted byte enable: 0001 byte, 0011 half, 1111 word
funct3  input  3  load/store width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
WDATA  input  32  store data, right-aligned
RDATA  output  32  load result, extended; held between loads
MemReady  output  1  one-cycle completion pulse, for both load and store
MemErr  output  1  one-cycle pulse coincident with MemReady on a rejected request
Busy  output  1  high from the cycle after acceptance through the MemReady cycle

Behaviour:
- Reset: state IDLE, wait counter 0, RDATA=0, MemReady=0, MemErr=0, Busy=0. Memory array is not cleared. Reset mid-operation aborts the request; a pending store is not committed.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE, when MemRead|MemWrite is sampled high:
  - Latch ADDR, BE, funct3, WDATA and the request type.
  - Go to WAIT if LATENCY>0, else to ACCESS.
  - Load the counter with LATENCY-1.
- WAIT: decrement the counter each cycle; go to ACCESS when the counter is 0. Exactly LATENCY cycles are spent in WAIT.
- ACCESS (one cycle): perform the access, pulse MemReady, return to IDLE.
- Latency: request sampled at edge t gives MemReady high during cycle t+LATENCY+1. Back-to-back: a new request can be accepted in the cycle after MemReady.
- Requests while Busy are ignored, not queued. Inputs may change after acceptance without effect.
- Validity checks (lane = ADDR[1:0]):
  - BE=0001: any lane.
  - BE=0011: lane must be 0 or 2.
  - BE=1111: lane must be 0.
  - Any other BE value is invalid.
  - MemRead and MemWrite both high at acceptance is invalid.
  - Invalid request: full latency still elapses; in ACCESS, MemErr=1, MemReady=1, memory unchanged, RDATA forced to 0.
- Store: the shifted enable is BE<<lane. WDATA is shifted left by 8*lane. Only enabled bytes of word ADDR[ADDR_WIDTH+1:2] are written; other bytes are preserved.
- Load: the word is shifted right by 8*lane, then extended:
  - 000: sign-extend byte
  - 100: zero-extend byte
  - 001: sign-extend half
  - 101: zero-extend half
  - 010: full word
  - Other funct3 on a load: MemErr.
  - RDATA updates at the ACCESS edge, so it is valid in the cycle after MemReady and is held until the next load completes.
- Stores and errors do not modify RDATA, except that an error forces it to 0.
- Read-after-write to the same address in consecutive requests returns the new data.
- Address wraps naturally within the ADDR_WIDTH+2 bit space; no out-of-range case.

Test Plan:
- Reset: assert RST for 2 cycles while MemRead=1 -> RDATA=0, MemReady=0, Busy=0; no request accepted until RST is low.
- Word store/load, LATENCY=2: SW 0xDEADBEEF at ADDR=0x010, then LW 0x010 -> each MemReady exactly 3 cycles after acceptance; RDATA=0xDEADBEEF.
- Byte/half merge: SW 0x11223344 at 0x020; SB 0xAA at 0x021; SH 0xBEEF at 0x022; LW 0x020 -> 0xBEEFAA44.
- Extension: word 0x80F0_7F81 at 0x030 ->
  - LB 0x030 = 0xFFFFFF81; LBU 0x030 = 0x00000081
  - LH 0x032 = 0xFFFF80F0; LHU 0x032 = 0x000080F0
- Errors: LW at 0x031; SH at 0x033; MemRead=MemWrite=1 -> MemErr and MemReady pulse together after the full latency; memory unchanged; RDATA=0.
- Abort and busy handling:
  - SW 0x12345678 at 0x040 over old value 0x0; assert RST during WAIT -> LW 0x040 returns 0x0 (store not committed).
  - A request pulsed while Busy is ignored: exactly one MemReady for the two requests.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, LATENCY wait states,
// byte-lane alignment, store byte merge and load sign/zero extension.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH+1:0] ADDR,
  input  logic [3:0]            BE,
  input  logic [2:0]            funct3,
  input  logic [31:0]           WDATA,
  output logic [31:0]           RDATA,
  output logic                  MemReady,
  output logic                  MemErr,
  output logic                  Busy
);

  localparam int         NUM_LANES = 4;
  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  typedef struct packed {
    logic                  wr;
    logic                  err;
    logic [ADDR_WIDTH+1:0] addr;
    logic [3:0]            be;
    logic [2:0]            f3;
    logic [31:0]           wdata;
  } req_t;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t req_q, req_d;
  logic [31:0] rdata_q;
  logic accept, be_ok, f3_ok;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     widx;
  logic [NUM_LANES-1:0]      be_sh;
  logic [NUM_LANES-1:0][7:0] wd_sh;
  logic [31:0]               rd_word, rd_sh, ld_ext;

  assign accept = (state_q == S_IDLE) && (MemRead || MemWrite);

  // Request capture and validity decode; the decision is frozen at acceptance.
  always_comb begin
    be_ok = 1'b0;
    case (BE)
      4'b0001: be_ok = 1'b1;
      4'b0011: be_ok = ~ADDR[0];
      4'b1111: be_ok = (ADDR[1:0] == 2'd0);
      default: be_ok = 1'b0;
    endcase
    f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_d       = req_q;
    req_d.wr    = MemWrite;
    req_d.err   = !be_ok || (MemRead && MemWrite) || (!MemWrite && !f3_ok);
    req_d.addr  = ADDR;
    req_d.be    = BE;
    req_d.f3    = funct3;
    req_d.wdata = WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= req_d;
    end
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (MemRead || MemWrite) state_d = (LATENCY > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    MemReady = (state_q == S_ACCESS);
    MemErr   = (state_q == S_ACCESS) && req_q.err;
    Busy     = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                                    cnt_d = CNT_INIT;
    else if (state_q == S_WAIT && cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign widx    = req_q.addr[ADDR_WIDTH+1:2];
  assign be_sh   = req_q.be << req_q.addr[1:0];
  assign wd_sh   = req_q.wdata << {req_q.addr[1:0], 3'b000};
  assign rd_word = mem[widx];
  assign rd_sh   = rd_word >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    ld_ext = rd_sh;
    case (req_q.f3)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b100:  ld_ext = {24'd0, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b101:  ld_ext = {16'd0, rd_sh[15:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  // Storage is never reset; a reset landing on the ACCESS edge drops the store.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == S_ACCESS && req_q.wr && !req_q.err) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be_sh[l]) mem[widx][l] <= wd_sh[l];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= 32'd0;
    end else if (state_q == S_ACCESS) begin
      if (req_q.err)      rdata_q <= 32'd0;
      else if (!req_q.wr) rdata_q <= ld_ext;
    end
  end

  assign RDATA = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized + directed bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;
  localparam int NB  = 2 ** (AW + 2);

  logic          CLK = 1'b0;
  logic          RST, MemRead, MemWrite;
  logic [AW+1:0] ADDR;
  logic [3:0]    BE;
  logic [2:0]    funct3;
  logic [31:0]   WDATA, RDATA;
  logic          MemReady, MemErr, Busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [NB];
  logic [31:0] rdata_m = 32'd0;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR),
    .BE(BE), .funct3(funct3), .WDATA(WDATA), .RDATA(RDATA), .MemReady(MemReady),
    .MemErr(MemErr), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Access width from BE; a legal access must be naturally aligned to that width.
  function automatic bit valid_m(bit rd, bit wr, int a, logic [3:0] be, logic [2:0] f3);
    int w;
    case (be)
      4'b0001: w = 1;
      4'b0011: w = 2;
      4'b1111: w = 4;
      default: return 1'b0;
    endcase
    if (rd && wr) return 1'b0;
    if (!wr && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    return (a % w) == 0;
  endfunction

  task automatic model_apply(input bit rd, input bit wr, input int a, input logic [3:0] be,
                             input logic [2:0] f3, input logic [31:0] wd, output bit exp_err);
    logic [31:0] word;
    int base;
    base    = a - (a % 4);
    exp_err = !valid_m(rd, wr, a, be, f3);
    if (exp_err) begin
      rdata_m = 32'd0;
    end else if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) mm[a + i] = wd[8*i +: 8];
    end else begin
      word = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
      word = word >> (8 * (a % 4));
      case (f3)
        3'b000:  rdata_m = 32'($signed(word[7:0]));
        3'b100:  rdata_m = 32'(word[7:0]);
        3'b001:  rdata_m = 32'($signed(word[15:0]));
        3'b101:  rdata_m = 32'(word[15:0]);
        default: rdata_m = word;
      endcase
    end
  endtask

  // Issue one request (called #1 after a rising edge with the DUT idle) and check it.
  task automatic do_req(input bit rd, input bit wr, input int a, input logic [3:0] be,
                        input logic [2:0] f3, input logic [31:0] wd, input string tag);
    bit exp_err, found;
    int n;
    MemRead = rd; MemWrite = wr; ADDR = (AW+2)'(a); BE = be; funct3 = f3; WDATA = wd;
    @(posedge CLK); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    ADDR = (AW+2)'($urandom); WDATA = $urandom; BE = 4'($urandom); funct3 = 3'($urandom);
    model_apply(rd, wr, a, be, f3, wd, exp_err);
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      @(negedge CLK); n++;
      checks++;
      if (Busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1 cycle %0d", tag, Busy, n); end
      if (MemReady === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != LAT + 1) begin
      errors++; $display("FAIL %s latency got %0d want %0d (found=%0b)", tag, n, LAT + 1, found);
    end
    checks++;
    if (MemErr !== exp_err) begin errors++; $display("FAIL %s memerr got %b want %b", tag, MemErr, exp_err); end
    @(posedge CLK); #1;
    checks++;
    if (MemReady !== 1'b0 || MemErr !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL %s pulse not single ready=%b err=%b busy=%b want 0", tag, MemReady, MemErr, Busy);
    end
    checks++;
    if (RDATA !== rdata_m) begin errors++; $display("FAIL %s rdata got %h want %h", tag, RDATA, rdata_m); end
  endtask

  task automatic test_reset();
    RST = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ADDR = '0; BE = 4'hF; funct3 = 3'b010; WDATA = '0;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (RDATA !== 32'd0 || MemReady !== 1'b0 || Busy !== 1'b0 || MemErr !== 1'b0) begin
        errors++; $display("FAIL reset rdata=%h ready=%b busy=%b err=%b want 0", RDATA, MemReady, Busy, MemErr);
      end
    end
    RST = 1'b0; MemRead = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_release busy got %b want 0", Busy); end
  endtask

  task automatic test_word();
    do_req(0, 1, 'h010, 4'hF, 3'b010, 32'hDEADBEEF, "sw_word");
    do_req(1, 0, 'h010, 4'hF, 3'b010, 32'h0, "lw_word");
    checks++;
    if (RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL word_value got %h want deadbeef", RDATA); end
  endtask

  task automatic test_merge();
    do_req(0, 1, 'h020, 4'hF, 3'b010, 32'h11223344, "merge_sw");
    do_req(0, 1, 'h021, 4'h1, 3'b000, 32'h000000AA, "merge_sb");
    do_req(0, 1, 'h022, 4'h3, 3'b001, 32'h0000BEEF, "merge_sh");
    do_req(1, 0, 'h020, 4'hF, 3'b010, 32'h0, "merge_lw");
    checks++;
    if (RDATA !== 32'hBEEFAA44) begin errors++; $display("FAIL merge_value got %h want beefaa44", RDATA); end
  endtask

  task automatic test_extension();
    logic [31:0] exp [4];
    logic [2:0]  f3s [4];
    int          adr [4];
    logic [3:0]  bes [4];
    exp = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80F0, 32'h000080F0};
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101};
    adr = '{'h030, 'h030, 'h032, 'h032};
    bes = '{4'h1, 4'h1, 4'h3, 4'h3};
    do_req(0, 1, 'h030, 4'hF, 3'b010, 32'h80F07F81, "ext_sw");
    for (int i = 0; i < 4; i++) begin
      do_req(1, 0, adr[i], bes[i], f3s[i], 32'h0, "ext_ld");
      checks++;
      if (RDATA !== exp[i]) begin errors++; $display("FAIL ext_value%0d got %h want %h", i, RDATA, exp[i]); end
    end
  endtask

  task automatic test_errors();
    do_req(1, 0, 'h031, 4'hF, 3'b010, 32'h0, "err_lw_misalign");
    checks++;
    if (RDATA !== 32'd0) begin errors++; $display("FAIL err_rdata got %h want 0", RDATA); end
    do_req(0, 1, 'h033, 4'h3, 3'b001, 32'h0000FFFF, "err_sh_misalign");
    do_req(1, 1, 'h030, 4'hF, 3'b010, 32'h12345678, "err_rd_wr");
    do_req(1, 0, 'h030, 4'hF, 3'b010, 32'h0, "err_unchanged");
    checks++;
    if (RDATA !== 32'h80F07F81) begin errors++; $display("FAIL err_mem_changed got %h want 80f07f81", RDATA); end
  endtask

  task automatic test_abort();
    int seen;
    do_req(0, 1, 'h040, 4'hF, 3'b010, 32'h0, "abort_init");
    MemWrite = 1'b1; ADDR = 'h040; BE = 4'hF; funct3 = 3'b010; WDATA = 32'h12345678;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    rdata_m = 32'd0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (MemReady === 1'b1 || Busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_activity got %0d want 0", seen); end
    @(posedge CLK); #1;
    do_req(1, 0, 'h040, 4'hF, 3'b010, 32'h0, "abort_lw");
    checks++;
    if (RDATA !== 32'd0) begin errors++; $display("FAIL abort_value got %h want 0", RDATA); end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    bit e;
    MemWrite = 1'b1; ADDR = 'h044; BE = 4'hF; funct3 = 3'b010; WDATA = 32'h00000055;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    model_apply(0, 1, 'h044, 4'hF, 3'b010, 32'h00000055, e);
    pulses = 0;
    @(negedge CLK);
    if (MemReady === 1'b1) pulses++;
    MemWrite = 1'b1; ADDR = 'h044; WDATA = 32'hCAFEF00D;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (MemReady === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL busy_ignore pulses got %0d want 1", pulses); end
    @(posedge CLK); #1;
    do_req(1, 0, 'h044, 4'hF, 3'b010, 32'h0, "busy_lw");
    checks++;
    if (RDATA !== 32'h00000055) begin errors++; $display("FAIL busy_value got %h want 00000055", RDATA); end
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] f3;
    logic [3:0] be;
    bit rd, wr;
    int a, pick;
    for (int w = 0; w < 16; w++) do_req(0, 1, 'h100 + 4*w, 4'hF, 3'b010, $urandom, "rnd_init");
    for (int k = 0; k < 80; k++) begin
      a    = 'h100 + int'($urandom_range(0, 63));
      pick = int'($urandom_range(0, 5));
      case (pick)
        0: f3 = 3'b000; 1: f3 = 3'b100; 2: f3 = 3'b001;
        3: f3 = 3'b101; 4: f3 = 3'b010; default: f3 = 3'($urandom_range(0, 7));
      endcase
      case (f3[1:0])
        2'b00:   be = 4'h1;
        2'b01:   be = 4'h3;
        default: be = 4'hF;
      endcase
      if ($urandom_range(0, 9) == 0) be = 4'($urandom);
      wr = 1'($urandom);
      rd = !wr || ($urandom_range(0, 9) == 0);
      do_req(rd, wr, a, be, f3, $urandom, "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_merge();
    test_extension();
    test_errors();
    test_abort();
    test_busy_ignore();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
